// File: rtl/io_byte_packer.sv
// io_byte_packer
//   Input stage ahead of the DES core. It samples the byte-wide pad bus on
//   rising edges of the slow pad clock, qualified by the pad valid line. The
//   bytes are packed into BW-bit blocks and handed to the core through a
//   1-deep valid/ready output slot.
//
// Ports
//   wb_clk_i        system clock, the only clock in this block
//   wb_rst_i        synchronous active-high reset
//   io_clk_i        raw pad clock (asynchronous, at least 4x slower)
//   io_valid_i      raw pad byte-valid
//   io_ctrl_i       raw pad block tag (1 = data, 0 = key)
//   io_data_i       raw pad byte
//   blk_data_o      packed block
//   blk_is_key_o    tag of blk_data_o (1 = key)
//   blk_valid_o     block available
//   blk_ready_i     core accepts the block
//   byte_cnt_o      bytes held in the partial block
//   overflow_o      sticky: a completed block was dropped
//   clr_overflow_i  clears overflow_o
//
// Output slot states
//   state   | meaning
//   S_EMPTY | no block held, blk_valid_o = 0
//   S_FULL  | block held and offered, blk_valid_o = 1
module io_byte_packer #(
  parameter int SYNC_STAGES     = 2,
  parameter int BYTES_PER_BLOCK = 8,
  parameter int MSB_FIRST       = 1
) (
  input  logic                           wb_clk_i,
  input  logic                           wb_rst_i,
  input  logic                           io_clk_i,
  input  logic                           io_valid_i,
  input  logic                           io_ctrl_i,
  input  logic [7:0]                     io_data_i,
  output logic [8*BYTES_PER_BLOCK-1:0]   blk_data_o,
  output logic                           blk_is_key_o,
  output logic                           blk_valid_o,
  input  logic                           blk_ready_i,
  output logic [2:0]                     byte_cnt_o,
  output logic                           overflow_o,
  input  logic                           clr_overflow_i
);

  localparam int BW = 8 * BYTES_PER_BLOCK;
  localparam logic [2:0] LAST = 3'(BYTES_PER_BLOCK - 1);

  typedef enum logic {S_EMPTY, S_FULL} state_t;

  // All pad lines go through one shared chain so they stay mutually aligned.
  logic [10:0]                   pad_raw;
  logic [SYNC_STAGES-1:0][10:0]  sync_q;
  logic                          clk_prev;
  logic                          clk_s;
  logic                          valid_s;
  logic                          ctrl_s;
  logic [7:0]                    data_s;
  logic                          strobe;

  assign pad_raw = {io_clk_i, io_valid_i, io_ctrl_i, io_data_i};
  assign clk_s   = sync_q[SYNC_STAGES-1][10];
  assign valid_s = sync_q[SYNC_STAGES-1][9];
  assign ctrl_s  = sync_q[SYNC_STAGES-1][8];
  assign data_s  = sync_q[SYNC_STAGES-1][7:0];
  assign strobe  = clk_s & ~clk_prev & valid_s;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      sync_q   <= '0;
      clk_prev <= 1'b0;
    end else begin
      sync_q[0] <= pad_raw;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      clk_prev <= clk_s;
    end
  end

  // Fill path
  logic [BW-1:0] shreg;
  logic [BW-1:0] shreg_next;
  logic [2:0]    cnt;
  logic [2:0]    base_cnt;
  logic          tag;
  logic          done;
  logic          is_last;

  always_comb begin
    shreg_next = shreg;
    if (MSB_FIRST != 0) begin
      shreg_next = {shreg[BW-9:0], data_s};
    end else begin
      shreg_next = {data_s, shreg[BW-1:8]};
    end
  end

  // A tag change restarts the block: the byte counts as the first one.
  assign base_cnt = ((cnt != 3'd0) && (ctrl_s != tag)) ? 3'd0 : cnt;
  assign is_last  = (base_cnt == LAST);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      shreg <= '0;
      cnt   <= 3'd0;
      tag   <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (strobe) begin
        shreg <= shreg_next;
        // Within a block the ctrl always matches the tag, so latching it on
        // every byte is equivalent to latching it on the first one.
        tag   <= ctrl_s;
        cnt   <= is_last ? 3'd0 : base_cnt + 3'd1;
        done  <= is_last;
      end
    end
  end

  assign byte_cnt_o = cnt;

  // Output slot; done marks the cycle in which shreg/tag hold a full block.
  state_t state;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state        <= S_EMPTY;
      blk_data_o   <= '0;
      blk_is_key_o <= 1'b0;
      blk_valid_o  <= 1'b0;
      overflow_o   <= 1'b0;
    end else begin
      if (clr_overflow_i) overflow_o <= 1'b0;
      case (state)
        S_EMPTY: begin
          if (done) begin
            blk_data_o   <= shreg;
            blk_is_key_o <= ~tag;
            blk_valid_o  <= 1'b1;
            state        <= S_FULL;
          end
        end
        S_FULL: begin
          if (blk_ready_i) begin
            if (done) begin
              blk_data_o   <= shreg;
              blk_is_key_o <= ~tag;
            end else begin
              blk_valid_o <= 1'b0;
              state       <= S_EMPTY;
            end
          end else if (done) begin
            // Placed after the clear so that a coincident set wins.
            overflow_o <= 1'b1;
          end
        end
        default: state <= S_EMPTY;
      endcase
    end
  end

endmodule
